alu_addsub_pipe: RTL

//  Parametrised, pipelined Y86 integer ALU. Performs ADD, SUB, AND and XOR on W-bit operands.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_seg_stage.sv | 100 ++++++++++
 rtl/alu_addsub_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | alu_pkg
// | Shared op encodings, CC bit indices and per-stage control payload for the
// | pipelined Y86 add/sub/logic ALU.
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    localparam int         CC_ZF    = 2;
    localparam int         CC_SF    = 1;
    localparam int         CC_OF    = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

    // Width-independent part of the stage payload; a, b', partial result and tag
    // travel beside it as W/TAG_W buses because a package cannot be parameterised.
    typedef struct packed {
        alu_op_e op;
        logic    carry;
        logic    zacc;
        logic    set_cc;
    } alu_ctl_t;

    function automatic logic op_is_arith(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seg_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | alu_seg_stage
// | One SEG-bit add/logic slice of the ALU plus its pipeline register.
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
module alu_seg_stage
    import alu_pkg::*;
#(
    parameter int W     = 64,
    parameter int SEG   = 16,
    parameter int TAG_W = 4,
    parameter int IDX   = 0,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             in_valid,
    input  alu_ctl_t         in_ctl,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_res,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output alu_ctl_t         out_ctl,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    output logic [W-1:0]     out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_of
);

    localparam int LO = IDX * SEG;

    logic [SEG-1:0] w_sa;
    logic [SEG-1:0] w_sb;
    logic [SEG-1:0] w_seg;
    logic [SEG:0]   w_sum;
    logic [W-1:0]   w_res;
    logic           w_of;

    logic             r_valid;
    alu_ctl_t         r_ctl;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    logic [TAG_W-1:0] r_tag;
    logic             r_of;

    always_comb begin
        w_sa  = in_a[LO +: SEG];
        w_sb  = in_b[LO +: SEG];
        w_sum = {1'b0, w_sa} + {1'b0, w_sb} + {{SEG{1'b0}}, in_ctl.carry};
        case (in_ctl.op)
            ALU_AND: w_seg = w_sa & w_sb;
            ALU_XOR: w_seg = w_sa ^ w_sb;
            default: w_seg = w_sum[SEG-1:0];
        endcase
        w_res            = in_res;
        w_res[LO +: SEG] = w_seg;
        // b is already b' here, so one equal-sign test covers both ADD and SUB
        w_of = 1'b0;
        if (LAST && op_is_arith(in_ctl.op))
            w_of = (in_a[W-1] == in_b[W-1]) && (w_res[W-1] != in_a[W-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctl   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_tag   <= '0;
            r_of    <= 1'b0;
        end else if (adv) begin
            r_valid       <= in_valid;
            r_ctl.op      <= in_ctl.op;
            r_ctl.carry   <= w_sum[SEG];
            r_ctl.zacc    <= in_ctl.zacc & (w_seg == '0);
            r_ctl.set_cc  <= in_ctl.set_cc;
            r_a           <= in_a;
            r_b           <= in_b;
            r_res         <= w_res;
            r_tag         <= in_tag;
            r_of          <= w_of;
        end
    end

    assign out_valid = r_valid;
    assign out_ctl   = r_ctl;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_res   = r_res;
    assign out_tag   = r_tag;
    assign out_of    = r_of;

endmodule
`default_nettype wire

// File: rtl/alu_addsub_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | alu_addsub_pipe
// | Pipelined Y86 ALU (ADD/SUB/AND/XOR) with ZF/SF/OF and valid/ready flow.
// | Optional CC register and cc_q port when ALU_CC_REG_EN is defined.
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int W     = 64,
    parameter int SEG   = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_of,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_CC_REG_EN
    ,
    output logic [2:0]       cc_q
`endif
);

    localparam int STAGES = (SEG > 0) ? (W / SEG) : 1;

    if ((SEG < 1) || (W % SEG != 0)) begin : g_bad_seg
        $error("alu_addsub_pipe: W must be a non-zero multiple of SEG");
    end

    // Index k feeds stage k; index k+1 is stage k's registered output
    logic [STAGES:0]   w_v;
    alu_ctl_t          w_ctl [0:STAGES];
    logic [W-1:0]      w_a   [0:STAGES];
    logic [W-1:0]      w_b   [0:STAGES];
    logic [W-1:0]      w_res [0:STAGES];
    logic [TAG_W-1:0]  w_tag [0:STAGES];
    logic [STAGES-1:0] w_of;

    alu_op_e w_op_in;
    logic    w_sub;
    logic    w_adv;
    logic    w_unused;

    assign w_op_in  = alu_op_e'(in_op);
    assign w_sub    = (w_op_in == ALU_SUB);
    assign w_adv    = !(out_valid && !out_ready);
    assign in_ready = w_adv;

    assign w_v[0]   = in_valid;
    assign w_ctl[0] = '{op: w_op_in, carry: w_sub, zacc: 1'b1, set_cc: in_set_cc};
    assign w_a[0]   = in_a;
    assign w_b[0]   = w_sub ? ~in_b : in_b;
    assign w_res[0] = '0;
    assign w_tag[0] = in_tag;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        alu_seg_stage #(
            .W     (W),
            .SEG   (SEG),
            .TAG_W (TAG_W),
            .IDX   (k),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (w_adv),
            .in_valid  (w_v[k]),
            .in_ctl    (w_ctl[k]),
            .in_a      (w_a[k]),
            .in_b      (w_b[k]),
            .in_res    (w_res[k]),
            .in_tag    (w_tag[k]),
            .out_valid (w_v[k+1]),
            .out_ctl   (w_ctl[k+1]),
            .out_a     (w_a[k+1]),
            .out_b     (w_b[k+1]),
            .out_res   (w_res[k+1]),
            .out_tag   (w_tag[k+1]),
            .out_of    (w_of[k])
        );
    end

    assign out_valid = w_v[STAGES];
    assign out_res   = w_res[STAGES];
    assign out_zf    = w_ctl[STAGES].zacc;
    assign out_sf    = w_res[STAGES][W-1];
    assign out_of    = w_of[STAGES-1];
    assign out_tag   = w_tag[STAGES];

    // Final-stage operands and carry have no consumer past the pipe
    assign w_unused = ^{w_ctl[STAGES], w_a[STAGES], w_b[STAGES], w_of};

`ifdef ALU_CC_REG_EN
    logic [2:0] r_cc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc <= CC_RESET;
        end else if (out_valid && out_ready && w_ctl[STAGES].set_cc) begin
            r_cc[CC_ZF] <= out_zf;
            r_cc[CC_SF] <= out_sf;
            r_cc[CC_OF] <= out_of;
        end
    end

    assign cc_q = r_cc;
`endif

endmodule
`default_nettype wire
